// File: rtl/serial_mag_comparator.sv
// ============================================================================
// Module      : serial_mag_comparator
// Description : Clocked MSB-first magnitude comparator for two N-bit operands.
//               Compares K bits per clock and reports exactly one of
//               gt / eq / lt, held until the next accepted start.
//               Optional macro EARLY_EXIT_EN: stop at the first differing
//               group (data-dependent latency). Without it, all N/K groups
//               are always scanned (constant-time).
// Ports       : clk     - clock, rising edge
//               reset   - synchronous active-high reset
//               start   - compare request, sampled only while idle
//               A, B    - operands, captured on the accepting edge
//               busy    - compare in progress
//               done    - one-cycle pulse, result flags valid
//               a_gt_b / a_eq_b / a_lt_b - result flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_mag_comparator #(
   parameter int N      = 16,
   parameter int K      = 1,
   parameter int SIGNED = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic         a_gt_b,
   output logic         a_eq_b,
   output logic         a_lt_b
);

   localparam int c_ngroups = N / K;
   localparam int c_gw      = (c_ngroups > 1) ? $clog2(c_ngroups) : 1;

   // Flipping the sign bit of both operands maps two's-complement ordering
   // onto unsigned ordering, so the group compare stays unsigned.
   localparam logic [N-1:0] c_sign_mask =
      (SIGNED != 0) ? {1'b1, {(N-1){1'b0}}} : {N{1'b0}};

   generate
      if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad_params
         $error("serial_mag_comparator: illegal N/K combination");
      end
   endgenerate

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_COMPARE = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      a_q, a_d;
   logic [N-1:0]      b_q, b_d;
   logic [c_gw-1:0]   g_q, g_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              gt_q, gt_d;
   logic              eq_q, eq_d;
   logic              lt_q, lt_d;

   logic [K-1:0]      w_grp_a;
   logic [K-1:0]      w_grp_b;
   logic              w_last;

`ifndef EARLY_EXIT_EN
   // Verdict from the most-significant differing group, kept hidden until
   // the final group so the flags stay 0 for the whole scan.
   logic              vgt_q, vgt_d;
   logic              vlt_q, vlt_d;
   logic              w_decided;
`endif

   assign w_grp_a = a_q[g_q*K +: K];
   assign w_grp_b = b_q[g_q*K +: K];
   assign w_last  = (g_q == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         g_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
`ifndef EARLY_EXIT_EN
         vgt_q   <= 1'b0;
         vlt_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         g_q     <= g_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
`ifndef EARLY_EXIT_EN
         vgt_q   <= vgt_d;
         vlt_q   <= vlt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      g_d     = g_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      gt_d    = gt_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
`ifndef EARLY_EXIT_EN
      vgt_d     = vgt_q;
      vlt_d     = vlt_q;
      w_decided = vgt_q | vlt_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A ^ c_sign_mask;
               b_d     = B ^ c_sign_mask;
               g_d     = c_gw'(c_ngroups - 1);
               busy_d  = 1'b1;
               gt_d    = 1'b0;
               eq_d    = 1'b0;
               lt_d    = 1'b0;
`ifndef EARLY_EXIT_EN
               vgt_d   = 1'b0;
               vlt_d   = 1'b0;
`endif
               state_d = S_COMPARE;
            end
         end

         S_COMPARE: begin
`ifdef EARLY_EXIT_EN
            if (w_grp_a != w_grp_b) begin
               gt_d    = (w_grp_a > w_grp_b);
               lt_d    = (w_grp_a < w_grp_b);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (w_last) begin
               eq_d    = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               g_d = g_q - 1'b1;
            end
`else
            if (!w_decided && (w_grp_a != w_grp_b)) begin
               vgt_d = (w_grp_a > w_grp_b);
               vlt_d = (w_grp_a < w_grp_b);
            end
            if (w_last) begin
               gt_d    = vgt_d;
               lt_d    = vlt_d;
               eq_d    = !(vgt_d | vlt_d);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               g_d = g_q - 1'b1;
            end
`endif
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign a_gt_b = gt_q;
   assign a_eq_b = eq_q;
   assign a_lt_b = lt_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_mag_comparator.sv
// ============================================================================
// Module      : tb_serial_mag_comparator
// Description : Self-checking bench for serial_mag_comparator. Four instances
//               (N16/K1, N16/K4, N8/K2 unsigned, N8/K2 signed) driven from a
//               directed vector table plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_mag_comparator;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  st;
   logic [15:0] opa [4];
   logic [15:0] opb [4];
   logic [3:0]  bz, dn, gt, eq, lt;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   serial_mag_comparator #(.N(16), .K(1), .SIGNED(0)) u_d0 (
      .clk(clk), .reset(reset), .start(st[0]), .A(opa[0]), .B(opb[0]),
      .busy(bz[0]), .done(dn[0]), .a_gt_b(gt[0]), .a_eq_b(eq[0]), .a_lt_b(lt[0]));

   serial_mag_comparator #(.N(16), .K(4), .SIGNED(0)) u_d1 (
      .clk(clk), .reset(reset), .start(st[1]), .A(opa[1]), .B(opb[1]),
      .busy(bz[1]), .done(dn[1]), .a_gt_b(gt[1]), .a_eq_b(eq[1]), .a_lt_b(lt[1]));

   serial_mag_comparator #(.N(8), .K(2), .SIGNED(0)) u_d2 (
      .clk(clk), .reset(reset), .start(st[2]), .A(opa[2][7:0]), .B(opb[2][7:0]),
      .busy(bz[2]), .done(dn[2]), .a_gt_b(gt[2]), .a_eq_b(eq[2]), .a_lt_b(lt[2]));

   serial_mag_comparator #(.N(8), .K(2), .SIGNED(1)) u_d3 (
      .clk(clk), .reset(reset), .start(st[3]), .A(opa[3][7:0]), .B(opb[3][7:0]),
      .busy(bz[3]), .done(dn[3]), .a_gt_b(gt[3]), .a_eq_b(eq[3]), .a_lt_b(lt[3]));

   typedef struct {
      int          dut;
      int          n;
      int          k;
      logic [15:0] a;
      logic [15:0] b;
      logic        egt;
      logic        eeq;
      logic        elt;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Edges from acceptance to done: first differing group sets it when
   // early exit is built in, otherwise always the full group count.
   function automatic int model_lat(input logic [15:0] a, input logic [15:0] b,
                                    input int n, input int k);
      int ng;
      ng = n / k;
`ifdef EARLY_EXIT_EN
      for (int g = ng - 1; g >= 0; g--) begin
         if (((({16'd0, a} ^ {16'd0, b}) >> (g * k)) & ((32'd1 << k) - 1)) != 0)
            return ng - g;
      end
`endif
      return ng;
   endfunction

   task automatic run_cmp(input int d, input logic [15:0] a, input logic [15:0] b,
                          input int n, input int k,
                          input logic egt, input logic eeq, input logic elt,
                          input string nm);
      int exp_m;
      int cnt;
      bit seen;
      exp_m   = model_lat(a, b, n, k);
      opa[d]  = a;
      opb[d]  = b;
      st[d]   = 1'b1;
      @(posedge clk); #1;
      st[d]   = 1'b0;
      // Operand changes after acceptance must not matter.
      opa[d]  = ~a;
      opb[d]  = a;
      check({nm, " busy@accept"}, {31'd0, bz[d]}, 32'd1);
      check({nm, " flags@accept"}, {29'd0, gt[d], eq[d], lt[d]}, 32'd0);
      cnt  = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         cnt++;
         if (dn[d]) seen = 1'b1;
      end
      check({nm, " latency"}, cnt, exp_m);
      check({nm, " flags"}, {29'd0, gt[d], eq[d], lt[d]}, {29'd0, egt, eeq, elt});
      check({nm, " busy@done"}, {31'd0, bz[d]}, 32'd0);
      @(posedge clk); #1;
      check({nm, " done pulse width"}, {31'd0, dn[d]}, 32'd0);
      check({nm, " flags held"}, {29'd0, gt[d], eq[d], lt[d]}, {29'd0, egt, eeq, elt});
   endtask

   initial begin
      int first;
      int pulses;
      int dcount;
      logic [2:0] fl;
      bit seen;

      tbl[0]  = '{0, 16, 1, 16'hDABF, 16'h6D5A, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{0, 16, 1, 16'h6D5A, 16'hDABF, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{0, 16, 1, 16'hA5A5, 16'hA5A5, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{0, 16, 1, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{0, 16, 1, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{0, 16, 1, 16'h1234, 16'h1235, 1'b0, 1'b0, 1'b1};
      tbl[6]  = '{1, 16, 4, 16'hA5A5, 16'hA5A5, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{1, 16, 4, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{1, 16, 4, 16'h0F00, 16'h1000, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{2, 8,  2, 16'h0080, 16'h0001, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{3, 8,  2, 16'h0080, 16'h0001, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{3, 8,  2, 16'h007F, 16'h0080, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{3, 8,  2, 16'h00FF, 16'h00FE, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{3, 8,  2, 16'h0080, 16'h0080, 1'b0, 1'b1, 1'b0};

      reset = 1'b1;
      st    = 4'b0;
      for (int i = 0; i < 4; i++) begin
         opa[i] = 16'h0;
         opb[i] = 16'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset busy", {28'd0, bz}, 32'd0);
      check("reset done", {28'd0, dn}, 32'd0);
      check("reset flags", {20'd0, gt, eq, lt}, 32'd0);

      for (int i = 0; i < 14; i++)
         run_cmp(tbl[i].dut, tbl[i].a, tbl[i].b, tbl[i].n, tbl[i].k,
                 tbl[i].egt, tbl[i].eeq, tbl[i].elt, $sformatf("vec%0d", i));

      // Reset on the 5th compare edge aborts without a done pulse.
      opa[0] = 16'hFFFF;
      opb[0] = 16'hFFFF;
      st[0]  = 1'b1;
      @(posedge clk); #1;
      st[0]  = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort busy", {31'd0, bz[0]}, 32'd0);
      check("abort flags", {29'd0, gt[0], eq[0], lt[0]}, 32'd0);
      dcount = 0;
      for (int i = 0; i < 20; i++) begin
         if (dn[0]) dcount++;
         @(posedge clk); #1;
      end
      check("abort no done", dcount, 32'd0);
      run_cmp(0, 16'h0001, 16'h0002, 16, 1, 1'b0, 1'b0, 1'b1, "post-abort");

      // Start while busy is ignored.
      opa[0] = 16'h0000;
      opb[0] = 16'h0000;
      st[0]  = 1'b1;
      @(posedge clk); #1;
      st[0]  = 1'b0;
      first  = 0;
      pulses = 0;
      fl     = 3'b000;
      for (int i = 1; i <= 30; i++) begin
         if (i == 3) begin
            st[0]  = 1'b1;
            opa[0] = 16'hFFFF;
         end
         @(posedge clk); #1;
         if (i == 3) st[0] = 1'b0;
         if (dn[0]) begin
            pulses++;
            if (first == 0) begin
               first = i;
               fl    = {gt[0], eq[0], lt[0]};
            end
         end
      end
      check("busy-start done edge", first, 32'd16);
      check("busy-start pulses", pulses, 32'd1);
      check("busy-start flags", {29'd0, fl}, 32'd2);

      // Start during the done cycle is accepted.
      opa[1] = 16'h1000;
      opb[1] = 16'h0FFF;
      st[1]  = 1'b1;
      @(posedge clk); #1;
      st[1]  = 1'b0;
      seen   = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         if (dn[1]) seen = 1'b1;
      end
      check("b2b first done", {31'd0, seen}, 32'd1);
      check("b2b first flags", {29'd0, gt[1], eq[1], lt[1]}, 32'd4);
      run_cmp(1, 16'h0001, 16'h0002, 16, 4, 1'b0, 1'b0, 1'b1, "b2b second");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
